// File: rtl/seq_generator.sv
// Serial pattern source: emits a selected 4-bit pattern MSB first, repeated
// rep_count times, with optional idle gap bits between repetitions.
module seq_generator #(
    parameter int   GAP_BITS   = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] seq_selector,
    input  logic [7:0] rep_count,
    output logic       out_seq,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] seq_sent
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    state_t     state;
    logic [3:0] pat_q;
    logic [1:0] bit_idx;
    logic [7:0] reps_left;
    logic [3:0] gap_cnt;
    logic [3:0] start_pat;

    always_comb begin
        start_pat = 4'b1001;
        case (seq_selector)
            2'd0:    start_pat = 4'b1001;
            2'd1:    start_pat = 4'b1100;
            2'd2:    start_pat = 4'b0110;
            default: start_pat = 4'b1010;
        endcase
    end

    // bit_idx is the index of the bit currently on out_seq, so each edge in
    // SEND either steps to the next bit or retires bit0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= 4'd0;
            bit_idx   <= 2'd0;
            reps_left <= 8'd0;
            gap_cnt   <= 4'd0;
            out_seq   <= IDLE_LEVEL;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            seq_sent  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_q     <= start_pat;
                        reps_left <= rep_count;
                        if (rep_count != 8'd0) begin
                            state     <= SEND;
                            bit_idx   <= 2'd3;
                            out_seq   <= start_pat[3];
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (bit_idx != 2'd0) begin
                        bit_idx <= bit_idx - 2'd1;
                        out_seq <= pat_q[bit_idx - 2'd1];
                    end else begin
                        seq_sent  <= seq_sent + 8'd1;
                        reps_left <= reps_left - 8'd1;
                        if (reps_left != 8'd1) begin
                            if (GAP_BITS > 0) begin
                                state     <= GAP;
                                gap_cnt   <= 4'(GAP_BITS - 1);
                                out_seq   <= IDLE_LEVEL;
                                out_valid <= 1'b0;
                            end else begin
                                bit_idx <= 2'd3;
                                out_seq <= pat_q[3];
                            end
                        end else begin
                            state     <= FIN;
                            out_seq   <= IDLE_LEVEL;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state     <= SEND;
                        bit_idx   <= 2'd3;
                        out_seq   <= pat_q[3];
                        out_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
// Scoreboard bench for seq_generator: one instance without gaps, one with
// GAP_BITS=2; per-cycle expected output words are queued and drained at negedge.
module tb_seq_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0;
    logic       start_g;
    logic [1:0] seq_selector;
    logic [7:0] rep_count;

    logic       out_seq0, out_valid0, busy0, done0;
    logic [7:0] seq_sent0;
    logic       out_seq_g, out_valid_g, busy_g, done_g;
    logic [7:0] seq_sent_g;

    typedef struct packed {
        logic valid;
        logic seq;
        logic busy;
        logic done;
    } exp_t;

    exp_t exp0_q[$];
    exp_t expg_q[$];
    exp_t m0;
    exp_t mg;

    int errors = 0;
    int checks = 0;
    int sent0  = 0;
    int sentg  = 0;

    seq_generator #(.GAP_BITS(0), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start0),
        .seq_selector(seq_selector), .rep_count(rep_count),
        .out_seq(out_seq0), .out_valid(out_valid0), .busy(busy0),
        .done(done0), .seq_sent(seq_sent0)
    );

    seq_generator #(.GAP_BITS(2), .IDLE_LEVEL(1'b0)) dut_g (
        .clk(clk), .rst(rst), .start(start_g),
        .seq_selector(seq_selector), .rep_count(rep_count),
        .out_seq(out_seq_g), .out_valid(out_valid_g), .busy(busy_g),
        .done(done_g), .seq_sent(seq_sent_g)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] pattern(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b1001;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b0110;
            default: return 4'b1010;
        endcase
    endfunction

    // Expected per-cycle words from cycle N+1 through the idle cycle after done.
    task automatic push_expected(input bit g, input logic [1:0] sel, input int rep);
        int         gap;
        logic [3:0] p;
        exp_t       e;
        gap = g ? 2 : 0;
        p   = pattern(sel);
        for (int r = 0; r < rep; r++) begin
            for (int b = 3; b >= 0; b--) begin
                e.valid = 1'b1; e.seq = p[b]; e.busy = 1'b1; e.done = 1'b0;
                if (g) expg_q.push_back(e); else exp0_q.push_back(e);
            end
            if (r < rep - 1) begin
                for (int k = 0; k < gap; k++) begin
                    e.valid = 1'b0; e.seq = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                    if (g) expg_q.push_back(e); else exp0_q.push_back(e);
                end
            end
        end
        e.valid = 1'b0; e.seq = 1'b0; e.busy = 1'b0; e.done = 1'b1;
        if (g) expg_q.push_back(e); else exp0_q.push_back(e);
        e.done = 1'b0;
        if (g) expg_q.push_back(e); else exp0_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp0_q.size() > 0) begin
            m0 = exp0_q.pop_front();
            checks++;
            if ({out_valid0, out_seq0, busy0, done0} !== m0) begin
                errors++;
                $display("[TB] FAIL stream0 t=%0t got v,s,b,d=%b required %b",
                         $time, {out_valid0, out_seq0, busy0, done0}, m0);
            end
        end
        if (expg_q.size() > 0) begin
            mg = expg_q.pop_front();
            checks++;
            if ({out_valid_g, out_seq_g, busy_g, done_g} !== mg) begin
                errors++;
                $display("[TB] FAIL stream_gap t=%0t got v,s,b,d=%b required %b",
                         $time, {out_valid_g, out_seq_g, busy_g, done_g}, mg);
            end
        end
    end

    task automatic launch(input bit g, input logic [1:0] sel, input logic [7:0] rep,
                          input bit push);
        @(posedge clk);
        #1;
        seq_selector = sel;
        rep_count    = rep;
        if (g) start_g = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0  = 1'b0;
        start_g = 1'b0;
        if (push) push_expected(g, sel, int'(rep));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 5000 && (exp0_q.size() > 0 || expg_q.size() > 0); i++) begin
            @(negedge clk);
            #1;
        end
        if (exp0_q.size() > 0 || expg_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout got %0d/%0d entries left required 0",
                     name, exp0_q.size(), expg_q.size());
            exp0_q.delete();
            expg_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_seq0, out_valid0, busy0, done0, seq_sent0} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset0 got %h required 000",
                     {out_seq0, out_valid0, busy0, done0, seq_sent0});
        end
        checks++;
        if ({out_seq_g, out_valid_g, busy_g, done_g, seq_sent_g} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_gap got %h required 000",
                     {out_seq_g, out_valid_g, busy_g, done_g, seq_sent_g});
        end
        rst = 1'b0;
        sent0 = 0;
        sentg = 0;
    endtask

    task automatic test_single();
        launch(1'b0, 2'd0, 8'd1, 1'b1);
        wait_drain("single");
        sent0 = (sent0 + 1) % 256;
        checks++;
        if (seq_sent0 !== 8'(sent0)) begin
            errors++;
            $display("[TB] FAIL single_count got %0d required %0d", seq_sent0, sent0);
        end
    endtask

    task automatic test_back_to_back();
        launch(1'b0, 2'd3, 8'd3, 1'b1);
        wait_drain("back_to_back");
        sent0 = (sent0 + 3) % 256;
        checks++;
        if (seq_sent0 !== 8'(sent0)) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d required %0d", seq_sent0, sent0);
        end
    endtask

    task automatic test_zero_rep();
        launch(1'b0, 2'd1, 8'd0, 1'b1);
        wait_drain("zero_rep");
        checks++;
        if (seq_sent0 !== 8'(sent0)) begin
            errors++;
            $display("[TB] FAIL zero_count got %0d required %0d", seq_sent0, sent0);
        end
    endtask

    task automatic test_ignore_start();
        launch(1'b0, 2'd0, 8'd2, 1'b1);
        @(posedge clk);
        #1;
        seq_selector = 2'd1;
        rep_count    = 8'd5;
        start0       = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_drain("ignore_start");
        sent0 = (sent0 + 2) % 256;
        checks++;
        if (seq_sent0 !== 8'(sent0)) begin
            errors++;
            $display("[TB] FAIL ignore_count got %0d required %0d", seq_sent0, sent0);
        end
    endtask

    task automatic test_gap();
        launch(1'b1, 2'd1, 8'd2, 1'b1);
        wait_drain("gap");
        sentg = (sentg + 2) % 256;
        checks++;
        if (seq_sent_g !== 8'(sentg)) begin
            errors++;
            $display("[TB] FAIL gap_count got %0d required %0d", seq_sent_g, sentg);
        end
    endtask

    task automatic test_abort();
        launch(1'b0, 2'd2, 8'd1, 1'b0);
        @(negedge clk);
        checks++;
        if ({out_valid0, out_seq0} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL abort_bit3 got %b required 10", {out_valid0, out_seq0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid0, out_seq0} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL abort_bit2 got %b required 11", {out_valid0, out_seq0});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_seq0, out_valid0, busy0, done0, seq_sent0, seq_sent_g} !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL abort_reset got %h required 00000",
                     {out_seq0, out_valid0, busy0, done0, seq_sent0, seq_sent_g});
        end
        sent0 = 0;
        sentg = 0;
    endtask

    task automatic test_wrap();
        launch(1'b0, 2'd2, 8'd255, 1'b1);
        wait_drain("wrap_preload");
        sent0 = (sent0 + 255) % 256;
        checks++;
        if (seq_sent0 !== 8'(sent0)) begin
            errors++;
            $display("[TB] FAIL wrap_preload got %0d required %0d", seq_sent0, sent0);
        end
        launch(1'b0, 2'd2, 8'd1, 1'b1);
        wait_drain("wrap");
        sent0 = (sent0 + 1) % 256;
        checks++;
        if (seq_sent0 !== 8'(sent0)) begin
            errors++;
            $display("[TB] FAIL wrap_count got %0d required %0d", seq_sent0, sent0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start0       = 1'b0;
        start_g      = 1'b0;
        seq_selector = 2'd0;
        rep_count    = 8'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_rep();
        test_ignore_start();
        test_gap();
        test_abort();
        test_wrap();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
